ov5640_dvp_tx: RTL and testbench



---
 rtl/ov5640_pkg.sv | 26 ++
 rtl/ov5640_dvp_timing.sv | 138 +++++++++++++
 rtl/ov5640_dvp_tx.sv | 89 ++++++++
 tb/tb_ov5640_dvp_tx.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640-style DVP transmitter.
// Holds the frame-timing state encoding and the RGB565 byte-order helpers.
package ov5640_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    HBLANK,
    VFRONT
  } dvp_tx_state_t;

  // The sensor sends the high byte of each RGB565 pixel first
  localparam logic BYTE_HI = 1'b0;
  localparam logic BYTE_LO = 1'b1;

  function automatic logic [7:0] rgb565_byte(input logic [15:0] px, input logic phase);
    return (phase == BYTE_LO) ? px[7:0] : px[15:8];
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov5640_dvp_timing.sv
// Frame/line timing generator for the DVP transmitter: state machine, counters,
// registered vsync/href/byte phase and the pixel fetch strobe for the stream side.
module ov5640_dvp_timing
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_BLANK    = 64,
  parameter int VSYNC_LEN  = 16,
  parameter int VBACK_LEN  = 32,
  parameter int VFRONT_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic vsync,
  output logic href,
  output logic byte_phase,
  output logic fetch,
  output logic fetch_first,
  output logic fetch_last,
  output logic resync,
  output logic frame_done
);

  localparam int HSPAN = 2 * H_ACTIVE + H_BLANK;
  localparam int HW    = (HSPAN > 1) ? $clog2(HSPAN) : 1;
  localparam int VW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BMAX  = max2(max2(VSYNC_LEN, VBACK_LEN), max2(VFRONT_LEN, H_BLANK));
  localparam int BW    = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(2 * H_ACTIVE - 1);
  localparam logic [HW-1:0] H_LASTPX = HW'(2 * H_ACTIVE - 2);
  localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] VS_LAST  = BW'(VSYNC_LEN - 1);
  localparam logic [BW-1:0] VB_LAST  = BW'(VBACK_LEN - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VF_LAST  = BW'(VFRONT_LEN - 1);

  dvp_tx_state_t   state, state_n;
  logic [HW-1:0]   h_cnt, h_n;
  logic [VW-1:0]   v_cnt, v_n;
  logic [BW-1:0]   b_cnt, b_n;

  always_comb begin
    state_n    = state;
    h_n        = h_cnt;
    v_n        = v_cnt;
    b_n        = b_cnt;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        v_n = '0;
        if (enable) begin
          state_n = VSYNC;
          b_n     = '0;
        end
      end
      VSYNC: begin
        if (b_cnt == VS_LAST) begin
          state_n = VBACK;
          b_n     = '0;
        end else begin
          b_n = b_cnt + 1'b1;
        end
      end
      VBACK: begin
        if (b_cnt == VB_LAST) begin
          state_n = ACTIVE;
          h_n     = '0;
          v_n     = '0;
        end else begin
          b_n = b_cnt + 1'b1;
        end
      end
      ACTIVE: begin
        if (h_cnt == H_LAST) begin
          state_n = HBLANK;
          b_n     = '0;
        end else begin
          h_n = h_cnt + 1'b1;
        end
      end
      HBLANK: begin
        if (b_cnt == HB_LAST) begin
          if (v_cnt == V_LAST) begin
            state_n = VFRONT;
            b_n     = '0;
          end else begin
            state_n = ACTIVE;
            h_n     = '0;
            v_n     = v_cnt + 1'b1;
          end
        end else begin
          b_n = b_cnt + 1'b1;
        end
      end
      VFRONT: begin
        if (b_cnt == VF_LAST) begin
          frame_done = 1'b1;
          b_n        = '0;
          state_n    = enable ? VSYNC : IDLE;
        end else begin
          b_n = b_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A pixel is fetched one cycle ahead of its high byte so the byte lands in a register
  assign fetch       = (state_n == ACTIVE) && !h_n[0];
  assign fetch_first = fetch && (h_n == '0) && (v_n == '0);
  assign fetch_last  = fetch && (h_n == H_LASTPX);
  // Stray beats are flushed from vsync up to (not including) the first pixel fetch
  assign resync      = (state == VSYNC) || ((state == VBACK) && !fetch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      b_cnt      <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      byte_phase <= 1'b0;
    end else begin
      state      <= state_n;
      h_cnt      <= h_n;
      v_cnt      <= v_n;
      b_cnt      <= b_n;
      vsync      <= (state_n == VSYNC);
      href       <= (state_n == ACTIVE);
      byte_phase <= (state_n == ACTIVE) && h_n[0];
    end
  end

endmodule

// File: rtl/ov5640_dvp_tx.sv
// OV5640-style DVP transmitter: AXI4-Stream RGB565 in, vsync/href/8-bit bytes out.
// Timing never waits for the stream; missing pixels go out as zeros and set underflow.
module ov5640_dvp_tx
  import ov5640_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_BLANK    = 64,
  parameter int VSYNC_LEN  = 16,
  parameter int VBACK_LEN  = 32,
  parameter int VFRONT_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        underflow,
  output logic        sync_err,
  output logic [15:0] frame_cnt
);

  logic       byte_phase;
  logic       fetch;
  logic       fetch_first;
  logic       fetch_last;
  logic       resync;
  logic       frame_done;
  logic       take;
  logic       discard;
  logic       pos_err;
  logic [7:0] lo_q;

  ov5640_dvp_timing #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LEN  (VSYNC_LEN),
    .VBACK_LEN  (VBACK_LEN),
    .VFRONT_LEN (VFRONT_LEN)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .vsync       (cam_vsync),
    .href        (cam_href),
    .byte_phase  (byte_phase),
    .fetch       (fetch),
    .fetch_first (fetch_first),
    .fetch_last  (fetch_last),
    .resync      (resync),
    .frame_done  (frame_done)
  );

  // During resync a start-of-frame beat is held back rather than swallowed
  assign s_axis_tready = fetch || (resync && !s_axis_tuser);
  assign take          = fetch && s_axis_tvalid;
  assign discard       = resync && s_axis_tvalid && !s_axis_tuser;
  assign pos_err       = take && ((s_axis_tuser && !fetch_first) || (s_axis_tlast != fetch_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_data  <= '0;
      lo_q      <= '0;
      underflow <= 1'b0;
      sync_err  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (fetch) begin
        cam_data <= take ? rgb565_byte(s_axis_tdata, BYTE_HI) : 8'h00;
        lo_q     <= take ? rgb565_byte(s_axis_tdata, BYTE_LO) : 8'h00;
      end else if (cam_href && (byte_phase == BYTE_HI)) begin
        cam_data <= lo_q;
      end else begin
        cam_data <= 8'h00;
      end
      if (fetch && !s_axis_tvalid) underflow <= 1'b1;
      if (discard || pos_err)      sync_err  <= 1'b1;
      if (frame_done)              frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// Self-checking bench for ov5640_dvp_tx on a tiny 4x2 frame (28-cycle period).
// Expected bytes are queued as pixels are scheduled and popped whenever href is high.
module tb_ov5640_dvp_tx;

  localparam int H_ACTIVE   = 4;
  localparam int V_ACTIVE   = 2;
  localparam int H_BLANK    = 3;
  localparam int VSYNC_LEN  = 2;
  localparam int VBACK_LEN  = 2;
  localparam int VFRONT_LEN = 2;
  localparam int LINE       = 2 * H_ACTIVE + H_BLANK;
  localparam int FIRST_ACT  = VSYNC_LEN + VBACK_LEN;
  localparam int PERIOD     = FIRST_ACT + V_ACTIVE * LINE + VFRONT_LEN;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        underflow;
  logic        sync_err;
  logic [15:0] frame_cnt;

  typedef struct {
    logic [15:0] data;
    logic        user;
    logic        last;
    logic        valid;
  } beat_t;

  beat_t      src_q[$];
  logic [7:0] exp_q[$];
  int         accepted = 0;
  int         checks   = 0;
  int         failures = 0;
  logic       mon_en   = 1'b0;

  ov5640_dvp_tx #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .VSYNC_LEN  (VSYNC_LEN),
    .VBACK_LEN  (VBACK_LEN),
    .VFRONT_LEN (VFRONT_LEN)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
    .underflow     (underflow),
    .sync_err      (sync_err),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  // Stream source: presents the queue head at negedge, pops it if the DUT is ready
  initial begin
    beat_t cur;
    logic  had;
    forever begin
      @(negedge clk);
      had = (src_q.size() > 0);
      if (had) begin
        cur           = src_q[0];
        s_axis_tvalid = cur.valid;
        s_axis_tdata  = cur.valid ? cur.data : 16'h0000;
        s_axis_tuser  = cur.valid & cur.user;
        s_axis_tlast  = cur.valid & cur.last;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h0000;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
      end
      #1;
      if (had && src_q.size() > 0 && s_axis_tready === 1'b1) begin
        if (src_q[0].valid) accepted++;
        void'(src_q.pop_front());
      end
    end
  end

  // Byte monitor: every href byte must match the scoreboard, data must be zero otherwise
  initial begin
    logic [7:0] exp_b;
    wait (mon_en);
    forever begin
      @(posedge clk); #1;
      checks++;
      if (cam_href === 1'b1) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_empty: cam_data=%02h but no byte expected at %0t", cam_data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          if (cam_data !== exp_b) begin
            failures++;
            $display("[TB] FAIL sb_byte: cam_data=%02h expected=%02h at %0t", cam_data, exp_b, $time);
          end
        end
      end else if (cam_data !== 8'h00) begin
        failures++;
        $display("[TB] FAIL idle_data: cam_data=%02h expected=00 with href low at %0t", cam_data, $time);
      end
    end
  end

  function automatic logic [1:0] model_sig(input int c, input int frames);
    int k;
    if (c >= PERIOD * frames) return 2'b00;
    k = c % PERIOD;
    if (k < VSYNC_LEN) return 2'b10;
    if (k < FIRST_ACT) return 2'b00;
    if (k < FIRST_ACT + V_ACTIVE * LINE) return (((k - FIRST_ACT) % LINE) < 2 * H_ACTIVE) ? 2'b01 : 2'b00;
    return 2'b00;
  endfunction

  function automatic logic [15:0] pix_val(input int n);
    logic [15:0] v;
    v = 16'h1234 + 16'(n) * 16'h4444;
    return v;
  endfunction

  task automatic push_pixel(input logic [15:0] d, input logic u, input logic l);
    beat_t b;
    b.data = d; b.user = u; b.last = l; b.valid = 1'b1;
    src_q.push_back(b);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic push_gap();
    beat_t b;
    b.data = 16'h0000; b.user = 1'b0; b.last = 1'b0; b.valid = 1'b0;
    src_q.push_back(b);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
  endtask

  task automatic push_junk(input logic [15:0] d);
    beat_t b;
    b.data = d; b.user = 1'b0; b.last = 1'b0; b.valid = 1'b1;
    src_q.push_back(b);
  endtask

  task automatic load_frame(input int f, input int gap_at, input int last_at);
    for (int l = 0; l < V_ACTIVE; l++) begin
      for (int p = 0; p < H_ACTIVE; p++) begin
        int idx;
        idx = l * H_ACTIVE + p;
        if (idx == gap_at) push_gap();
        else push_pixel(pix_val(f * 8 + idx), (idx == 0),
                        (l == 0 && last_at >= 0) ? (p == last_at) : (p == H_ACTIVE - 1));
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    src_q.delete();
    exp_q.delete();
    accepted = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs whole frames with enable held, dropping it during line 1 of the last frame
  task automatic run_frames(input int frames, input int exp_acc);
    int         drop;
    logic [1:0] es;
    drop = PERIOD * (frames - 1) + FIRST_ACT + LINE + 2;
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c <= PERIOD * frames; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      es = model_sig(c, frames);
      checks++;
      if ({cam_vsync, cam_href} !== es) begin
        failures++;
        $display("[TB] FAIL timing c=%0d: vsync/href=%b expected=%b", c, {cam_vsync, cam_href}, es);
      end
      if (c > 0 && (c % PERIOD) == 0) begin
        checks++;
        if (frame_cnt !== 16'(c / PERIOD)) begin
          failures++;
          $display("[TB] FAIL frame_cnt c=%0d: got %0d expected %0d", c, frame_cnt, c / PERIOD);
        end
      end
      if (c == drop) begin
        @(negedge clk);
        enable = 1'b0;
      end
    end
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_tready: got %b expected 0", s_axis_tready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: %0d bytes never seen, expected 0", exp_q.size());
    end
    checks++;
    if (accepted != exp_acc || src_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL accepted: got %0d beats (%0d left) expected %0d (0 left)",
               accepted, src_q.size(), exp_acc);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_uf, input logic exp_se);
    checks++;
    if (underflow !== exp_uf) begin
      failures++;
      $display("[TB] FAIL %s_underflow: got %b expected %b", tag, underflow, exp_uf);
    end
    checks++;
    if (sync_err !== exp_se) begin
      failures++;
      $display("[TB] FAIL %s_sync_err: got %b expected %b", tag, sync_err, exp_se);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cam_vsync, cam_href, cam_data, s_axis_tready, underflow, sync_err, frame_cnt} !== 29'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: vs=%b hr=%b d=%02h rdy=%b uf=%b se=%b fc=%0d expected all 0",
               cam_vsync, cam_href, cam_data, s_axis_tready, underflow, sync_err, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cam_vsync, cam_href, s_axis_tready} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL idle_hold: vs/hr/rdy=%b expected 000", {cam_vsync, cam_href, s_axis_tready});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_full_frame();
    reset_dut();
    load_frame(0, -1, -1);
    run_frames(1, 8);
    check_flags("full", 1'b0, 1'b0);
  endtask

  task automatic test_underflow();
    reset_dut();
    load_frame(0, 2, -1);
    run_frames(1, 7);
    check_flags("underflow", 1'b1, 1'b0);
  endtask

  task automatic test_resync();
    reset_dut();
    push_junk(16'hAAAA);
    push_junk(16'hBBBB);
    push_junk(16'hCCCC);
    load_frame(0, -1, -1);
    run_frames(1, 11);
    check_flags("resync", 1'b0, 1'b1);
  endtask

  task automatic test_tlast_err();
    reset_dut();
    load_frame(0, -1, 2);
    run_frames(1, 8);
    check_flags("tlast", 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    reset_dut();
    load_frame(0, -1, -1);
    load_frame(1, -1, -1);
    run_frames(2, 16);
    check_flags("b2b", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    reset_dut();
    load_frame(0, -1, -1);
    for (int i = 0; i < 2 * H_ACTIVE * V_ACTIVE; i++) exp_q.push_back(8'h00);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk); #1;
    repeat (PERIOD + FIRST_ACT + 2) @(posedge clk);
    #1;
    checks++;
    if ({cam_href, underflow, frame_cnt} !== {1'b1, 1'b1, 16'd1}) begin
      failures++;
      $display("[TB] FAIL pre_reset: href=%b uf=%b fc=%0d expected 1 1 1", cam_href, underflow, frame_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({cam_vsync, cam_href, cam_data, s_axis_tready, underflow, sync_err, frame_cnt} !== 29'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: vs=%b hr=%b d=%02h rdy=%b uf=%b se=%b fc=%0d expected all 0",
               cam_vsync, cam_href, cam_data, s_axis_tready, underflow, sync_err, frame_cnt);
    end
    reset_dut();
    load_frame(2, -1, -1);
    run_frames(1, 8);
    check_flags("post_reset", 1'b0, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    s_axis_tdata  = 16'h0000;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    test_reset();
    test_full_frame();
    test_underflow();
    test_resync();
    test_tlast_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
